pw_pattern_generator: RTL and testbench



---
 rtl/pw_pattern_generator_pkg.sv | 19 +
 rtl/pw_pattern_generator_if.sv | 26 ++
 rtl/pw_pattern_generator_lfsr8.sv | 36 +++
 rtl/pw_pattern_generator.sv | 193 +++++++++++++++++++
 tb/tb_pw_pattern_generator.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pw_pattern_generator_pkg.sv
// Shared types and constants for the pattern generator: state encoding,
// noise LFSR tap mask / seed, and the pattern-length clamp.
package pw_pattern_generator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic [7:0] clamp_len(input logic [7:0] req_len,
                                           input logic [7:0] max_len);
    clamp_len = (req_len > max_len) ? max_len : req_len;
  endfunction

endpackage

// File: rtl/pw_pattern_generator_if.sv
// Control/stream bundle between a register block (master) and the
// pattern generator (slave).
interface pw_pattern_generator_if #(
  parameter int pPATTERN_BYTES = 8
);
  logic                          I_start;
  logic                          I_stop;
  logic [pPATTERN_BYTES*8-1:0]   I_pattern;
  logic [7:0]                    I_pattern_bytes;
  logic [7:0]                    I_gap;
  logic [7:0]                    I_repeat;
  logic [7:0]                    O_fe_data;
  logic                          O_fe_data_valid;
  logic                          O_busy;
  logic                          O_done;

  modport master (
    output I_start, I_stop, I_pattern, I_pattern_bytes, I_gap, I_repeat,
    input  O_fe_data, O_fe_data_valid, O_busy, O_done
  );

  modport slave (
    input  I_start, I_stop, I_pattern, I_pattern_bytes, I_gap, I_repeat,
    output O_fe_data, O_fe_data_valid, O_busy, O_done
  );
endinterface

// File: rtl/pw_pattern_generator_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) producing distractor bytes;
// load takes priority over stepping.
module pw_lfsr8
  import pw_pattern_generator_pkg::*;
(
  input  logic       clk,
  input  logic       reset_i,
  input  logic       en,
  input  logic       load,
  output logic [7:0] lfsr_out
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = LFSR_SEED;
    end else if (en) begin
      lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_out = lfsr_q;

endmodule

// File: rtl/pw_pattern_generator.sv
// Programmable byte-stream source feeding the pattern matcher front end.
// Optional build macro PW_PATGEN_NOISE_EN fills gap cycles with LFSR bytes.
module pw_pattern_generator
  import pw_pattern_generator_pkg::*;
#(
  parameter int pPATTERN_BYTES = 8
)
(
  input  logic                  fe_clk,
  input  logic                  reset_i,
  pw_pattern_generator_if.slave bus
);

  localparam int PW = pPATTERN_BYTES * 8;

  state_e          state_q, state_d;
  logic [PW-1:0]   pat_q, pat_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      gap_q, gap_d;
  logic [7:0]      rep_lim_q, rep_lim_d;
  logic [7:0]      idx_q, idx_d;
  logic [7:0]      rep_q, rep_d;
  logic [7:0]      gcnt_q, gcnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [7:0]      start_len_s;
  logic [7:0]      idx_nxt_s;
  logic            wrap_s;
  logic [7:0]      rep_nxt_s;
  logic            last_s;
  logic            finish_s;

  function automatic logic [7:0] pick_byte(input logic [PW-1:0] pat,
                                           input logic [7:0]    idx);
    pick_byte = 8'h00;
    for (int i = 0; i < pPATTERN_BYTES; i++) begin
      if (idx == 8'(i)) pick_byte = pat[8*i +: 8];
    end
  endfunction

  assign start_len_s = clamp_len(bus.I_pattern_bytes, 8'(pPATTERN_BYTES));
  assign idx_nxt_s   = ((idx_q + 8'd1) == len_q) ? 8'd0 : (idx_q + 8'd1);
  assign wrap_s      = (idx_nxt_s == 8'd0);
  assign rep_nxt_s   = wrap_s ? (rep_q + 8'd1) : rep_q;
  // R=0 means run forever: the repetition counter wraps but never terminates
  assign last_s      = wrap_s && (rep_lim_q != 8'd0) && (rep_nxt_s == rep_lim_q);

`ifdef PW_PATGEN_NOISE_EN
  logic [7:0] noise_byte_s;
  logic       noise_step_s;

  pw_lfsr8 u_lfsr (
    .clk      (fe_clk),
    .reset_i  (reset_i),
    .en       (noise_step_s),
    .load     (state_q == ST_IDLE),
    .lfsr_out (noise_byte_s)
  );
`endif

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= 8'd0;
      gap_q     <= 8'd0;
      rep_lim_q <= 8'd0;
      idx_q     <= 8'd0;
      rep_q     <= 8'd0;
      gcnt_q    <= 8'd0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      rep_lim_q <= rep_lim_d;
      idx_q     <= idx_d;
      rep_q     <= rep_d;
      gcnt_q    <= gcnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    gap_d     = gap_q;
    rep_lim_d = rep_lim_q;
    idx_d     = idx_q;
    rep_d     = rep_q;
    gcnt_d    = gcnt_q;
    finish_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.I_start && !bus.I_stop) begin
          pat_d     = bus.I_pattern;
          len_d     = start_len_s;
          gap_d     = bus.I_gap;
          rep_lim_d = bus.I_repeat;
          idx_d     = 8'd0;
          rep_d     = 8'd0;
          gcnt_d    = 8'd0;
          if (start_len_s == 8'd0) begin
            finish_s = 1'b1;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        idx_d = idx_nxt_s;
        rep_d = rep_nxt_s;
        if (bus.I_stop || last_s) begin
          state_d  = ST_IDLE;
          finish_s = 1'b1;
        end else if (gap_q == 8'd0) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_GAP;
          gcnt_d  = gap_q;
        end
      end
      ST_GAP: begin
        gcnt_d = gcnt_q - 8'd1;
        if (bus.I_stop) begin
          state_d  = ST_IDLE;
          finish_s = 1'b1;
        end else if (gcnt_q == 8'd1) begin
          state_d = ST_SEND;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are computed from the upcoming state so they appear registered
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = finish_s;
`ifdef PW_PATGEN_NOISE_EN
    noise_step_s = 1'b0;
`endif
    case (state_d)
      ST_SEND: begin
        data_d  = pick_byte(pat_d, idx_d);
        valid_d = 1'b1;
      end
      ST_GAP: begin
`ifdef PW_PATGEN_NOISE_EN
        data_d       = noise_byte_s;
        valid_d      = 1'b1;
        noise_step_s = 1'b1;
`else
        data_d  = data_q;
        valid_d = 1'b0;
`endif
      end
      ST_IDLE: begin
        data_d  = data_q;
        valid_d = 1'b0;
      end
      default: begin
        data_d  = data_q;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.O_fe_data       = data_q;
  assign bus.O_fe_data_valid = valid_q;
  assign bus.O_busy          = busy_q;
  assign bus.O_done          = done_q;

endmodule

// File: tb/tb_pw_pattern_generator.sv
// Directed, table-driven bench for pw_pattern_generator (8-byte build);
// gap expectations follow PW_PATGEN_NOISE_EN when it is defined.
module tb_pw_pattern_generator;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  pb;
    logic [7:0]  gap;
    logic [7:0]  rp;
    logic [63:0] pat;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_busy;
    logic        exp_done;
    logic        chk_data;
  } vec_t;

  logic fe_clk;
  logic reset_i;
  int   n_tests;
  int   n_fail;

  vec_t        vecs[$];
  logic [7:0]  cur_pb, cur_gap, cur_rp;
  logic [63:0] cur_pat;
  int          noise_k;
  logic [7:0]  noise_seq [6];

  pw_pattern_generator_if #(.pPATTERN_BYTES(8)) bus ();

  pw_pattern_generator #(.pPATTERN_BYTES(8)) dut (
    .fe_clk  (fe_clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, act, exp);
    end
  endtask

  task automatic cfg(input logic [7:0] pb, input logic [7:0] g,
                     input logic [7:0] rp, input logic [63:0] pat);
    cur_pb  = pb;
    cur_gap = g;
    cur_rp  = rp;
    cur_pat = pat;
    noise_k = 0;
  endtask

  task automatic row(input logic r, input logic s, input logic p, input logic ev,
                     input logic [7:0] ed, input logic eb, input logic edn,
                     input logic cd);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p;
    v.pb = cur_pb; v.gap = cur_gap; v.rp = cur_rp; v.pat = cur_pat;
    v.exp_valid = ev; v.exp_data = ed; v.exp_busy = eb; v.exp_done = edn;
    v.chk_data = cd;
    vecs.push_back(v);
  endtask

  task automatic gap_row(input logic [7:0] hold);
`ifdef PW_PATGEN_NOISE_EN
    row(1'b0, 1'b0, 1'b0, 1'b1, noise_seq[noise_k], 1'b1, 1'b0, 1'b1);
`else
    row(1'b0, 1'b0, 1'b0, 1'b0, hold, 1'b1, 1'b0, 1'b1);
`endif
    noise_k++;
  endtask

  initial begin
    int nvalid;
    int done_at;
    logic all_busy;

    n_tests = 0;
    n_fail  = 0;
    noise_seq[0] = 8'h01; noise_seq[1] = 8'h02; noise_seq[2] = 8'h04;
    noise_seq[3] = 8'h08; noise_seq[4] = 8'h11; noise_seq[5] = 8'h23;
    reset_i             = 1'b1;
    bus.I_start         = 1'b0;
    bus.I_stop          = 1'b0;
    bus.I_pattern       = 64'h0;
    bus.I_pattern_bytes = 8'd0;
    bus.I_gap           = 8'd0;
    bus.I_repeat        = 8'd0;

    // reset state
    cfg(8'd0, 8'd0, 8'd0, 64'h0);
    row(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    // B=3, G=0, R=1
    cfg(8'd3, 8'd0, 8'd1, 64'h332211);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // B=2, G=2, R=2: bytes at +1,+4,+7,+10, done at +11
    cfg(8'd2, 8'd2, 8'd2, 64'h332211);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    gap_row(8'h11); gap_row(8'h11);
    row(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
    gap_row(8'h22); gap_row(8'h22);
    row(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    gap_row(8'h11); gap_row(8'h11);
    row(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // length 200 clamps to 8
    cfg(8'd200, 8'd0, 8'd1, 64'h8877665544332211);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    for (int k = 1; k < 8; k++) row(1'b0, 1'b0, 1'b0, 1'b1, 8'((k + 1) * 17), 1'b1, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // B=0: done pulse only
    cfg(8'd0, 8'd0, 8'd1, 64'h332211);
    row(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // start+stop in idle: nothing
    cfg(8'd3, 8'd0, 8'd1, 64'h332211);
    row(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // start while busy ignored, restart on the done cycle
    cfg(8'd3, 8'd0, 8'd1, 64'h332211);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    cfg(8'd1, 8'd0, 8'd1, 64'hCCBBAA);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    row(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // R=0 continuous, stop on the 20th byte
    cfg(8'd3, 8'd0, 8'd0, 64'h332211);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    for (int k = 2; k <= 20; k++) row(1'b0, 1'b0, 1'b0, 1'b1, 8'((((k - 1) % 3) + 1) * 17), 1'b1, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // stop during a gap
    cfg(8'd2, 8'd2, 8'd0, 64'h332211);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    gap_row(8'h11);
    row(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // reset in the middle of SEND
    cfg(8'd3, 8'd0, 8'd1, 64'h332211);
    row(1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1);
    row(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge fe_clk);
      reset_i             = vecs[i].rst;
      bus.I_start         = vecs[i].start;
      bus.I_stop          = vecs[i].stop;
      bus.I_pattern       = vecs[i].pat;
      bus.I_pattern_bytes = vecs[i].pb;
      bus.I_gap           = vecs[i].gap;
      bus.I_repeat        = vecs[i].rp;
      @(posedge fe_clk);
      #1;
      chk("valid", i, 32'(bus.O_fe_data_valid), 32'(vecs[i].exp_valid));
      chk("busy",  i, 32'(bus.O_busy),          32'(vecs[i].exp_busy));
      chk("done",  i, 32'(bus.O_done),          32'(vecs[i].exp_done));
      if (vecs[i].chk_data) chk("data", i, 32'(bus.O_fe_data), 32'(vecs[i].exp_data));
    end

    // B=2, R=3, G=0: six bytes, done exactly 7 cycles after the start edge
    @(negedge fe_clk);
    reset_i             = 1'b0;
    bus.I_stop          = 1'b0;
    bus.I_start         = 1'b1;
    bus.I_pattern       = 64'h5AA5;
    bus.I_pattern_bytes = 8'd2;
    bus.I_gap           = 8'd0;
    bus.I_repeat        = 8'd3;
    nvalid   = 0;
    done_at  = 0;
    all_busy = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge fe_clk);
      #1;
      if (bus.O_fe_data_valid) nvalid++;
      if (bus.O_done && done_at == 0) done_at = c;
      if (c <= 6 && !bus.O_busy) all_busy = 1'b0;
      @(negedge fe_clk);
      bus.I_start = 1'b0;
      if (done_at != 0) break;
    end
    chk("seq_valid_count", -1, 32'(nvalid), 32'd6);
    chk("seq_done_offset", -1, 32'(done_at), 32'd7);
    chk("seq_busy_held",   -1, 32'(all_busy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
